mesh_port_switch: RTL and testbench

- Parametrised N-port packet switch node for the mesh router fabric; successor of the fixed 4x4 mesh terminal node.
- Per-input FIFO buffering, header-based routing to any output port, per-output round-robin arbitration, and atomic broadcast.
- Uses the same pndng/pop terminal handshake on both sides, so nodes chain directly or attach to bench terminals.

---
 rtl/mesh_port_switch.sv | 181 ++++++++++++++++++
 tb/tb_mesh_port_switch.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_port_switch.sv
// Mesh router node: per-input FIFOs, header routing, per-output
// round-robin unicast arbitration and atomic all-or-nothing broadcast.
module mesh_port_switch #(
  parameter int NUM_PORTS  = 4,
  parameter int PCKG_SZ    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8,
  parameter logic [ID_W-1:0] BDCST = ID_W'(8'hFF)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS*PCKG_SZ-1:0]   data_out_i_in,
  input  logic [NUM_PORTS-1:0]           pndng_i_in,
  output logic [NUM_PORTS-1:0]           popin,
  output logic [NUM_PORTS*PCKG_SZ-1:0]   data_out,
  output logic [NUM_PORTS-1:0]           pndng,
  input  logic [NUM_PORTS-1:0]           pop,
  output logic [NUM_PORTS-1:0]           fifo_full,
  output logic [15:0]                    drop_cnt
);

  localparam int N  = NUM_PORTS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PCKG_SZ-1:0] mem_q [N][FIFO_DEPTH];
  logic [AW-1:0]      wp_q  [N];
  logic [AW-1:0]      rp_q  [N];
  logic [CW-1:0]      cnt_q [N];

  logic [PW-1:0]      rr_q  [N];
  logic [PW-1:0]      rr_d  [N];
  logic [PW-1:0]      bp_q, bp_d;

  logic [N-1:0]       vld_q, vld_d;
  logic [PCKG_SZ-1:0] dat_q [N];
  logic [PCKG_SZ-1:0] dat_d [N];
  logic [15:0]        drop_q, drop_d;

  logic [PCKG_SZ-1:0] head [N];
  logic [ID_W-1:0]    dest [N];
  logic [PW-1:0]      tgt  [N];
  logic [N-1:0]       full, hv, is_bc, is_uc, is_bad;
  logic [N-1:0]       hpop, ofree, resv;
  logic [N-1:0]       push;

  always_comb begin
    for (int p = 0; p < N; p++) begin
      full[p]   = (cnt_q[p] == CW'(FIFO_DEPTH));
      hv[p]     = (cnt_q[p] != '0);
      head[p]   = mem_q[p][rp_q[p]];
      dest[p]   = head[p][PCKG_SZ-1 -: ID_W];
      tgt[p]    = dest[p][PW-1:0];
      is_bc[p]  = hv[p] && (dest[p] == BDCST);
      is_uc[p]  = hv[p] && !is_bc[p] && (dest[p] < ID_W'(N));
      is_bad[p] = hv[p] && !is_bc[p] && !is_uc[p];
    end
  end

  assign push  = pndng_i_in & ~full & {N{reset}};
  assign ofree = ~vld_q | pop;

  always_comb begin
    logic          bc_found;
    logic          found;
    logic [PW-1:0] bc_src;
    int            idx;
    int            win;
    int            nbad;
    logic [16:0]   sum;
    hpop     = is_bad;
    rr_d     = rr_q;
    bp_d     = bp_q;
    vld_d    = vld_q & ~pop;
    dat_d    = dat_q;
    resv     = '0;
    bc_found = 1'b0;
    bc_src   = '0;
    found    = 1'b0;
    idx      = 0;
    win      = 0;
    nbad     = 0;
    sum      = '0;

    for (int k = 0; k < N; k++) begin
      idx = (int'(bp_q) + k) % N;
      if (!bc_found && is_bc[idx]) begin
        bc_found = 1'b1;
        bc_src   = PW'(idx);
      end
    end

    // A broadcast holds every target output until all are free at once.
    if (bc_found) begin
      resv = ~(N'(1) << bc_src);
      if ((resv & ofree) == resv) begin
        for (int o = 0; o < N; o++) begin
          if (resv[o]) begin
            vld_d[o] = 1'b1;
            dat_d[o] = head[bc_src];
          end
        end
        hpop[bc_src] = 1'b1;
        bp_d = PW'((int'(bc_src) + 1) % N);
      end
    end

    for (int o = 0; o < N; o++) begin
      found = 1'b0;
      win   = 0;
      if (!resv[o] && ofree[o]) begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(rr_q[o]) + k) % N;
          if (!found && is_uc[idx] && (tgt[idx] == PW'(o))) begin
            found = 1'b1;
            win   = idx;
          end
        end
      end
      if (found) begin
        vld_d[o]  = 1'b1;
        dat_d[o]  = head[win];
        hpop[win] = 1'b1;
        rr_d[o]   = PW'((win + 1) % N);
      end
    end

    for (int p = 0; p < N; p++) begin
      nbad = nbad + int'(is_bad[p]);
    end
    sum    = {1'b0, drop_q} + 17'(nbad);
    drop_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < N; p++) begin
        wp_q[p]  <= '0;
        rp_q[p]  <= '0;
        cnt_q[p] <= '0;
        rr_q[p]  <= '0;
        dat_q[p] <= '0;
      end
      bp_q   <= '0;
      vld_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int p = 0; p < N; p++) begin
        if (push[p]) wp_q[p] <= wp_q[p] + AW'(1);
        if (hpop[p]) rp_q[p] <= rp_q[p] + AW'(1);
        cnt_q[p] <= cnt_q[p] + CW'(push[p]) - CW'(hpop[p]);
        rr_q[p]  <= rr_d[p];
        dat_q[p] <= dat_d[p];
      end
      bp_q   <= bp_d;
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < N; p++) begin
      if (push[p]) begin
        mem_q[p][wp_q[p]] <= data_out_i_in[p*PCKG_SZ +: PCKG_SZ];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N; p++) begin
      data_out[p*PCKG_SZ +: PCKG_SZ] = dat_q[p];
    end
  end

  assign popin     = push;
  assign pndng     = vld_q;
  assign fifo_full = full;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mesh_port_switch.sv
// Bench for mesh_port_switch: upstream terminals fed from queues,
// per-output scoreboard checked whenever a port is popped.
module tb_mesh_port_switch;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   pin = '0;
  logic [N-1:0]   popin;
  logic [N*W-1:0] dout;
  logic [N-1:0]   pndng;
  logic [N-1:0]   pop_r = '0;
  logic [N-1:0]   fifo_full;
  logic [15:0]    drop_cnt;

  mesh_port_switch #(
    .NUM_PORTS(N), .PCKG_SZ(W), .FIFO_DEPTH(4), .ID_W(8), .BDCST(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_out_i_in(din),
    .pndng_i_in(pin),
    .popin(popin),
    .data_out(dout),
    .pndng(pndng),
    .pop(pop_r),
    .fifo_full(fifo_full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int got [N];
  logic [W-1:0] src_q [N][$];
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] mon_e;

  initial for (int i = 0; i < N; i++) got[i] = 0;

  // Scoreboard: every packet taken downstream must be the oldest expected.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int o = 0; o < N; o++) begin
        if (pndng[o] && pop_r[o]) begin
          got[o]++;
          checks++;
          if (exp_q[o].size() == 0) begin
            errors++;
            $display("FAIL out%0d_unexpected got %h expected nothing",
                     o, dout[o*W +: W]);
          end else begin
            mon_e = exp_q[o].pop_front();
            if (dout[o*W +: W] !== mon_e) begin
              errors++;
              $display("FAIL out%0d_data got %h expected %h",
                       o, dout[o*W +: W], mon_e);
            end
          end
        end
      end
    end
  end

  function automatic void drive();
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0) begin
        pin[p] = 1'b1;
        din[p*W +: W] = src_q[p][0];
      end else begin
        pin[p] = 1'b0;
        din[p*W +: W] = '0;
      end
    end
  endfunction

  task automatic step();
    logic [N-1:0] tk;
    @(negedge clk);
    tk = popin & pin;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++)
      if (tk[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    drive();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    pop_r = '0;
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(output bit ok);
    bit idle;
    ok = 1'b0;
    pop_r = '1;
    for (int i = 0; i < 200; i++) begin
      idle = (pndng == '0);
      for (int p = 0; p < N; p++)
        if (src_q[p].size() != 0 || exp_q[p].size() != 0) idle = 1'b0;
      if (idle) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    pop_r = '0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    pin = '1;
    din = {N{32'h01_00_00_99}};
    #1;
    checks++;
    if (popin !== '0) begin
      errors++; $display("FAIL rst_popin got %b expected 0000", popin);
    end
    checks++;
    if (pndng !== '0) begin
      errors++; $display("FAIL rst_pndng got %b expected 0000", pndng);
    end
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL rst_data got %h expected 0", dout);
    end
    checks++;
    if (fifo_full !== '0) begin
      errors++; $display("FAIL rst_full got %b expected 0000", fifo_full);
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_drop got %0d expected 0", drop_cnt);
    end
    pin = '0;
    din = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step();
    checks++;
    if (pndng !== '0) begin
      errors++; $display("FAIL rst_idle got %b expected 0000", pndng);
    end
  endtask

  task automatic test_unicast();
    bit ok;
    apply_reset();
    src_q[0].push_back(32'h02_00_00_AA);
    exp_q[2].push_back(32'h02_00_00_AA);
    drive();
    #1;
    checks++;
    if (popin[0] !== 1'b1) begin
      errors++; $display("FAIL uc_popin got %b expected 1", popin[0]);
    end
    step();
    checks++;
    if (pndng !== 4'b0000) begin
      errors++; $display("FAIL uc_early got %b expected 0000", pndng);
    end
    step();
    checks++;
    if (pndng !== 4'b0100 || dout[2*W +: W] !== 32'h020000AA) begin
      errors++;
      $display("FAIL uc_latency got %b/%h expected 0100/020000aa",
               pndng, dout[2*W +: W]);
    end
    pop_r = 4'b0100;
    step();
    pop_r = '0;
    checks++;
    if (pndng[2] !== 1'b0) begin
      errors++; $display("FAIL uc_pop got %b expected 0", pndng[2]);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL uc_drain got timeout expected idle");
    end
  endtask

  task automatic test_contention();
    bit ok;
    int base, c1, c6;
    logic [W-1:0] pk;
    apply_reset();
    pop_r = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      pk = 32'h01_00_00_A0 + 32'(r); src_q[0].push_back(pk);
      pk = 32'h01_00_00_B0 + 32'(r); src_q[1].push_back(pk);
      pk = 32'h01_00_00_D0 + 32'(r); src_q[3].push_back(pk);
    end
    for (int r = 0; r < 2; r++) begin
      exp_q[1].push_back(32'h01_00_00_A0 + 32'(r));
      exp_q[1].push_back(32'h01_00_00_B0 + 32'(r));
      exp_q[1].push_back(32'h01_00_00_D0 + 32'(r));
    end
    drive();
    base = got[1];
    c1 = -1;
    c6 = -100;
    for (int i = 0; i < 50; i++) begin
      step();
      if (c1 < 0 && got[1] >= base + 1) c1 = cyc;
      if (got[1] >= base + 6) begin
        c6 = cyc;
        break;
      end
    end
    checks++;
    if (c6 - c1 !== 5) begin
      errors++;
      $display("FAIL rr_b2b got span %0d cycles expected 5", c6 - c1);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_drain got timeout expected idle");
    end
  endtask

  task automatic test_broadcast();
    bit ok;
    apply_reset();
    src_q[0].push_back(32'h03_00_00_33);
    exp_q[3].push_back(32'h03_00_00_33);
    drive();
    for (int i = 0; i < 10 && pndng[3] !== 1'b1; i++) step();
    checks++;
    if (pndng[3] !== 1'b1) begin
      errors++; $display("FAIL bc_setup got %b expected 1", pndng[3]);
    end
    pop_r = 4'b0111;
    src_q[1].push_back(32'hFF_00_00_55);
    src_q[3].push_back(32'h00_00_00_0C);
    src_q[2].push_back(32'h02_00_00_22);
    exp_q[0].push_back(32'hFF_00_00_55);
    exp_q[0].push_back(32'h00_00_00_0C);
    exp_q[2].push_back(32'hFF_00_00_55);
    exp_q[2].push_back(32'h02_00_00_22);
    exp_q[3].push_back(32'hFF_00_00_55);
    drive();
    repeat (6) step();
    checks++;
    if (pndng !== 4'b1000 || dout[3*W +: W] !== 32'h03000033) begin
      errors++;
      $display("FAIL bc_hold got %b/%h expected 1000/03000033",
               pndng, dout[3*W +: W]);
    end
    pop_r = 4'b1000;
    step();
    pop_r = '0;
    checks++;
    if (pndng !== 4'b1101) begin
      errors++; $display("FAIL bc_atomic got %b expected 1101", pndng);
    end
    checks++;
    if (dout[0 +: W] !== 32'hFF000055 || dout[2*W +: W] !== 32'hFF000055 ||
        dout[3*W +: W] !== 32'hFF000055) begin
      errors++;
      $display("FAIL bc_data got %h expected ff000055 on 0,2,3", dout);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bc_drain got timeout expected idle");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      src_q[2].push_back(32'h00_00_20_00 + 32'(i));
      exp_q[0].push_back(32'h00_00_20_00 + 32'(i));
    end
    drive();
    repeat (10) step();
    checks++;
    if (fifo_full[2] !== 1'b1 || popin[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got full=%b popin=%b expected 1/0",
               fifo_full[2], popin[2]);
    end
    checks++;
    if (src_q[2].size() !== 1) begin
      errors++;
      $display("FAIL bp_held got %0d waiting expected 1", src_q[2].size());
    end
    checks++;
    if (pndng !== 4'b0001 || dout[0 +: W] !== 32'h00002000) begin
      errors++;
      $display("FAIL bp_out got %b/%h expected 0001/00002000",
               pndng, dout[0 +: W]);
    end
    drain(ok);
    checks++;
    if (!ok || fifo_full !== '0) begin
      errors++;
      $display("FAIL bp_drain got ok=%b full=%b expected 1/0000",
               ok, fifo_full);
    end
  endtask

  task automatic test_invalid();
    bit seen;
    apply_reset();
    pop_r = '1;
    src_q[3].push_back(32'h07_00_00_01);
    src_q[3].push_back(32'h07_00_00_02);
    drive();
    step();
    step();
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++; $display("FAIL inv_first got %0d expected 1", drop_cnt);
    end
    step();
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++; $display("FAIL inv_second got %0d expected 2", drop_cnt);
    end
    seen = 1'b0;
    repeat (5) begin
      step();
      if (pndng !== '0) seen = 1'b1;
    end
    checks++;
    if (seen || drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL inv_quiet got out=%b drop=%0d expected 0/2",
               seen, drop_cnt);
    end
    pop_r = '0;
  endtask

  task automatic test_async_reset();
    bit ok, seen;
    apply_reset();
    for (int i = 0; i < 6; i++) src_q[0].push_back(32'h01_00_00_C0 + 32'(i));
    src_q[3].push_back(32'h07_00_00_EE);
    drive();
    repeat (8) step();
    checks++;
    if (pndng[1] !== 1'b1 || fifo_full[0] !== 1'b1 || drop_cnt !== 16'd1)
    begin
      errors++;
      $display("FAIL ar_setup got %b/%b/%0d expected 1/1/1",
               pndng[1], fifo_full[0], drop_cnt);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pndng !== '0 || fifo_full !== '0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ar_async got %b/%b/%0d expected 0000/0000/0",
               pndng, fifo_full, drop_cnt);
    end
    checks++;
    if (popin !== '0) begin
      errors++; $display("FAIL ar_popin got %b expected 0000", popin);
    end
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    drive();
    repeat (2) step();
    reset = 1'b1;
    pop_r = '1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (pndng !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL ar_ghost got output expected none");
    end
    src_q[0].push_back(32'h01_00_00_77);
    exp_q[1].push_back(32'h01_00_00_77);
    drive();
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ar_resume got timeout expected idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unicast();
    test_contention();
    test_broadcast();
    test_backpressure();
    test_invalid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
